// File: rtl/vma_sched_pkg.sv
// Shared types and constants for the VMA request scheduler.
package vma_sched_pkg;

    // Microcode VMA source selector.
    typedef enum logic [1:0] {
        SRC_AD      = 2'd0,
        SRC_PCMAGIC = 2'd1,
        SRC_HELD    = 2'd2,
        SRC_INC     = 2'd3
    } vma_src_t;

    // UCR4 VMA register control. Code 2 is unused by the datapath.
    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_INC  = 2'd1,
        SEL_LOAD = 2'd3
    } vma_sel_t;

    // Scheduler state encoding, kept as plain constants for older tools.
    typedef logic [1:0] sched_state_t;
    localparam sched_state_t ST_IDLE    = 2'd0;
    localparam sched_state_t ST_SAVE    = 2'd1;
    localparam sched_state_t ST_RETRY   = 2'd2;
    localparam sched_state_t ST_RESTORE = 2'd3;

    // Bit positions inside the one-hot grant vector {trap,pf,uc,diag}.
    localparam int GNT_DIAG = 0;
    localparam int GNT_UC   = 1;
    localparam int GNT_PF   = 2;
    localparam int GNT_TRAP = 3;

    // Width of the page-fail retry down-counter.
    localparam int RETRY_CW = 3;

endpackage

// File: rtl/vma_brk_qual.sv
// Address-break qualification: cycle-type mask, hit compare, sticky pending flag.
module vma_brk_qual
    import vma_sched_pkg::*;
#(
    parameter logic [2:0] BRK_MASK_DEF = 3'b111
) (
    input  logic       clk,
    input  logic       CROBAR,
    input  logic [2:0] cycType,
    input  logic       matchIn,
    input  logic       brkEn,
    input  logic       brkMaskWr,
    input  logic [2:0] brkMaskIn,
    input  logic       brkAck,
    output logic       brkPending
);

    logic [2:0] brk_mask;
    logic       brk_hit;

    // Hit uses the mask already in the register, so a new mask qualifies from the next cycle.
    always_comb begin
        brk_hit = brkEn & matchIn & (|(cycType & brk_mask));
    end

    // Mask register, writable in any scheduler state.
    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            brk_mask <= BRK_MASK_DEF;
        end else if (brkMaskWr) begin
            brk_mask <= brkMaskIn;
        end
    end

    // Sticky pending flag; a fresh hit wins over a simultaneous acknowledge.
    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            brkPending <= 1'b0;
        end else if (brk_hit) begin
            brkPending <= 1'b1;
        end else if (brkAck) begin
            brkPending <= 1'b0;
        end
    end

endmodule

// File: rtl/vma_sched.sv
// VMA request arbiter and page-fail retry sequencer.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | arbitrate trap > pf > uc > diag, one grant per cycle
// SAVE    | VMA copied into HELD (one cycle)
// RETRY   | VMA held while the retry counter runs down; trap aborts
// RESTORE | VMA reloaded from HELD (one cycle), then back to IDLE
module vma_sched
    import vma_sched_pkg::*;
#(
    parameter int         RETRY_CYC    = 3,
    parameter logic [2:0] BRK_MASK_DEF = 3'b111
) (
    input  logic       clk,
    input  logic       CROBAR,
    input  logic       ucReq,
    input  logic [1:0] ucSrc,
    input  logic       trapReq,
    input  logic       pfReq,
    input  logic       diagWr,
    input  logic [2:0] cycType,
    input  logic       matchIn,
    input  logic       brkEn,
    input  logic       brkMaskWr,
    input  logic [2:0] brkMaskIn,
    input  logic       brkAck,
    output logic [1:0] vmaSel,
    output logic       vmaAdSel,
    output logic       condVmaMagic,
    output logic       selHeld,
    output logic       loadVmaHeld,
    output logic       loadAdrBrk,
    output logic [3:0] grant,
    output logic       busy,
    output logic       brkPending
);

    sched_state_t        state, state_nx;
    logic [RETRY_CW-1:0] cnt, cnt_nx;

    vma_sel_t   sel_nx;
    logic       ad_nx, magic_nx, held_nx, ldh_nx, ldb_nx;
    logic [3:0] gnt_nx;

    // Next state, retry count and the control word to present next cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sel_nx   = SEL_HOLD;
        ad_nx    = 1'b0;
        magic_nx = 1'b0;
        held_nx  = 1'b0;
        ldh_nx   = 1'b0;
        ldb_nx   = 1'b0;
        gnt_nx   = 4'b0000;
        case (state)
            ST_IDLE: begin
                if (trapReq) begin
                    sel_nx           = SEL_LOAD;
                    magic_nx         = 1'b1;
                    gnt_nx[GNT_TRAP] = 1'b1;
                end else if (pfReq) begin
                    state_nx       = ST_SAVE;
                    ldh_nx         = 1'b1;
                    gnt_nx[GNT_PF] = 1'b1;
                end else if (ucReq) begin
                    gnt_nx[GNT_UC] = 1'b1;
                    case (vma_src_t'(ucSrc))
                        SRC_AD: begin
                            sel_nx = SEL_LOAD;
                            ad_nx  = 1'b1;
                        end
                        SRC_PCMAGIC: begin
                            sel_nx   = SEL_LOAD;
                            magic_nx = 1'b1;
                        end
                        SRC_HELD: begin
                            sel_nx  = SEL_LOAD;
                            held_nx = 1'b1;
                        end
                        default: begin
                            sel_nx = SEL_INC;
                        end
                    endcase
                end else if (diagWr) begin
                    ldb_nx           = 1'b1;
                    gnt_nx[GNT_DIAG] = 1'b1;
                end
            end
            ST_SAVE: begin
                state_nx = ST_RETRY;
                cnt_nx   = RETRY_CW'(RETRY_CYC - 1);
            end
            ST_RETRY: begin
                if (trapReq) begin
                    // Trap abandons the retry; HELD is left as saved.
                    state_nx         = ST_IDLE;
                    cnt_nx           = '0;
                    sel_nx           = SEL_LOAD;
                    magic_nx         = 1'b1;
                    gnt_nx[GNT_TRAP] = 1'b1;
                end else if (cnt == '0) begin
                    state_nx = ST_RESTORE;
                    sel_nx   = SEL_LOAD;
                    held_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt - RETRY_CW'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, counter and all outputs are registered together.
    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            vmaSel       <= SEL_HOLD;
            vmaAdSel     <= 1'b0;
            condVmaMagic <= 1'b0;
            selHeld      <= 1'b0;
            loadVmaHeld  <= 1'b0;
            loadAdrBrk   <= 1'b0;
            grant        <= 4'b0000;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            vmaSel       <= sel_nx;
            vmaAdSel     <= ad_nx;
            condVmaMagic <= magic_nx;
            selHeld      <= held_nx;
            loadVmaHeld  <= ldh_nx;
            loadAdrBrk   <= ldb_nx;
            grant        <= gnt_nx;
            busy         <= (state_nx != ST_IDLE);
        end
    end

    vma_brk_qual #(
        .BRK_MASK_DEF (BRK_MASK_DEF)
    ) u_brk (
        .clk        (clk),
        .CROBAR     (CROBAR),
        .cycType    (cycType),
        .matchIn    (matchIn),
        .brkEn      (brkEn),
        .brkMaskWr  (brkMaskWr),
        .brkMaskIn  (brkMaskIn),
        .brkAck     (brkAck),
        .brkPending (brkPending)
    );

endmodule

// File: tb/tb_vma_sched.sv
// Directed and random checks of vma_sched against a phase-count reference model.
module tb_vma_sched;

    localparam int RC = 3;

    logic       clk = 1'b0;
    logic       CROBAR;
    logic       ucReq;
    logic [1:0] ucSrc;
    logic       trapReq;
    logic       pfReq;
    logic       diagWr;
    logic [2:0] cycType;
    logic       matchIn;
    logic       brkEn;
    logic       brkMaskWr;
    logic [2:0] brkMaskIn;
    logic       brkAck;
    logic [1:0] vmaSel;
    logic       vmaAdSel;
    logic       condVmaMagic;
    logic       selHeld;
    logic       loadVmaHeld;
    logic       loadAdrBrk;
    logic [3:0] grant;
    logic       busy;
    logic       brkPending;

    int n_eval = 0;
    int n_fail = 0;

    // Reference model: ph = -1 when idle, else cycles elapsed since the pf grant.
    int         ph;
    logic [2:0] m_mask;
    logic       m_pend;
    logic [13:0] exp_v;
    logic [13:0] obs_v;

    assign obs_v = {vmaSel, vmaAdSel, condVmaMagic, selHeld, loadVmaHeld,
                    loadAdrBrk, grant, busy, brkPending};

    vma_sched #(
        .RETRY_CYC    (RC),
        .BRK_MASK_DEF (3'b111)
    ) dut (
        .clk          (clk),
        .CROBAR       (CROBAR),
        .ucReq        (ucReq),
        .ucSrc        (ucSrc),
        .trapReq      (trapReq),
        .pfReq        (pfReq),
        .diagWr       (diagWr),
        .cycType      (cycType),
        .matchIn      (matchIn),
        .brkEn        (brkEn),
        .brkMaskWr    (brkMaskWr),
        .brkMaskIn    (brkMaskIn),
        .brkAck       (brkAck),
        .vmaSel       (vmaSel),
        .vmaAdSel     (vmaAdSel),
        .condVmaMagic (condVmaMagic),
        .selHeld      (selHeld),
        .loadVmaHeld  (loadVmaHeld),
        .loadAdrBrk   (loadAdrBrk),
        .grant        (grant),
        .busy         (busy),
        .brkPending   (brkPending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ucReq = 0; ucSrc = 0; trapReq = 0; pfReq = 0; diagWr = 0;
        cycType = 0; matchIn = 0; brkEn = 0; brkMaskWr = 0; brkMaskIn = 0; brkAck = 0;
    endtask

    task automatic model_reset();
        ph = -1;
        m_mask = 3'b111;
        m_pend = 1'b0;
    endtask

    // Advance the model by one clock using the inputs the DUT samples at this edge.
    task automatic model_edge();
        logic [1:0] s = 0;
        logic a = 0, m = 0, h = 0, lh = 0, lb = 0, hit;
        logic [3:0] g = 0;
        bit trap_out = 0;
        if (ph < 0) begin
            if (trapReq) trap_out = 1;
            else if (pfReq) begin ph = 0; lh = 1; g = 4'b0100; end
            else if (ucReq) begin
                g = 4'b0010;
                case (ucSrc)
                    2'd0: begin s = 3; a = 1; end
                    2'd1: begin s = 3; m = 1; end
                    2'd2: begin s = 3; h = 1; end
                    default: s = 1;
                endcase
            end else if (diagWr) begin lb = 1; g = 4'b0001; end
        end else if (ph == 0) begin
            ph = 1;
        end else if (ph <= RC) begin
            if (trapReq) begin trap_out = 1; ph = -1; end
            else if (ph == RC) begin ph = RC + 1; s = 3; h = 1; end
            else ph++;
        end else begin
            ph = -1;
        end
        if (trap_out) begin s = 3; m = 1; g = 4'b1000; end
        hit = brkEn & matchIn & (|(cycType & m_mask));
        m_pend = hit | (m_pend & ~brkAck);
        if (brkMaskWr) m_mask = brkMaskIn;
        exp_v = {s, a, m, h, lh, lb, g, (ph >= 0), m_pend};
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag, 32'(obs_v), 32'(exp_v));
    endtask

    initial begin
        int bc;
        clear_inputs();
        model_reset();
        CROBAR = 1'b1;
        #1;
        check("reset_outputs", 32'(obs_v), 32'd0);
        repeat (2) @(negedge clk);
        CROBAR = 1'b0;

        // Microcode load from AD, then increment.
        ucReq = 1; ucSrc = 2'd0;
        step("uc_ad");
        check("uc_ad_grant", 32'(grant), 32'b0010);
        ucSrc = 2'd3;
        step("uc_inc");
        check("uc_inc_sel", 32'(vmaSel), 32'd1);
        ucReq = 0;
        step("idle_after_uc");

        // All four requesters at once: trap, then pf, uc only after restore.
        trapReq = 1; pfReq = 1; ucReq = 1; ucSrc = 2'd1; diagWr = 1;
        step("all_trap");
        check("all_trap_grant", 32'(grant), 32'b1000);
        trapReq = 0;
        step("all_pf_save");
        check("pf_save_ldheld", 32'(loadVmaHeld), 32'd1);
        pfReq = 0;
        bc = 1;
        for (int i = 0; i < 8; i++) begin
            step("pf_sequence");
            if (busy) bc++;
            if (grant[1]) ucReq = 0;
            if (grant[0]) diagWr = 0;
        end
        check("pf_busy_cycles", 32'(bc), 32'(RC + 2));
        clear_inputs();

        // Trap during the second retry cycle skips the restore.
        pfReq = 1;
        step("pf2_save");
        pfReq = 0;
        step("pf2_retry1");
        step("pf2_retry2");
        trapReq = 1;
        step("pf2_trap_abort");
        check("pf2_abort_busy", 32'(busy), 32'd0);
        trapReq = 0;
        step("pf2_idle");

        // Address-break mask qualification and sticky pending.
        brkMaskWr = 1; brkMaskIn = 3'b101;
        step("brk_mask101");
        brkMaskWr = 0; brkEn = 1; matchIn = 1; cycType = 3'b010;
        step("brk_nohit_101");
        check("brk_nohit_pend", 32'(brkPending), 32'd0);
        brkMaskWr = 1; brkMaskIn = 3'b010;
        step("brk_maskwr_same_cycle");
        brkMaskWr = 0;
        step("brk_hit_010");
        check("brk_hit_pend", 32'(brkPending), 32'd1);
        brkAck = 1;
        step("brk_ack_with_hit");
        matchIn = 0;
        step("brk_ack_nohit");
        brkAck = 0; matchIn = 1; cycType = 3'b000;
        step("brk_cyc_zero");
        clear_inputs();

        // Asynchronous reset in the middle of the retry.
        pfReq = 1;
        step("rst_pf_save");
        pfReq = 0;
        step("rst_retry1");
        step("rst_retry2");
        #2;
        CROBAR = 1'b1;
        #1;
        check("async_reset", 32'(obs_v), 32'd0);
        model_reset();
        @(negedge clk);
        CROBAR = 1'b0;
        brkEn = 1; matchIn = 1; cycType = 3'b001;
        step("rst_mask_default");
        check("rst_mask_pend", 32'(brkPending), 32'd1);
        clear_inputs();
        brkAck = 1;
        step("rst_ack");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            trapReq   = ($urandom_range(0, 7) == 0);
            pfReq     = ($urandom_range(0, 5) == 0);
            ucReq     = 1'($urandom);
            ucSrc     = 2'($urandom);
            diagWr    = 1'($urandom);
            cycType   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (3'b001 << $urandom_range(0, 2));
            matchIn   = 1'($urandom);
            brkEn     = 1'($urandom);
            brkMaskWr = ($urandom_range(0, 9) == 0);
            brkMaskIn = 3'($urandom);
            brkAck    = ($urandom_range(0, 3) == 0);
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule

// File: doc/vma_sched.md
Name: vma_sched

Overview:
Sequencer and arbiter for the VMA register section. It takes VMA update requests from four sources and issues one select per clock to the VMA/PC/HELD/ADR_BRK registers: trap vector, page-fail save, microcode load/increment, and front-end DATAO APR. It also runs the address-break qualification state machine that raises a sticky break trap. Sits between CON/MCL request decode and the VMA datapath.

Parameters:
RETRY_CYC, 3, cycles to hold the page-fail retry state before restoring VMA from HELD (1..7)
BRK_MASK_DEF, 3'b111, reset value of address-break cycle-type enable mask {fetch,read,write}

Ports:
clk  in  1  EBOX VMA clock
CROBAR  in  1  asynchronous active-high reset
ucReq  in  1  microcode VMA update request
ucSrc  in  2  0=AD, 1=PC+MAGIC, 2=HELD_OR_PC, 3=increment
trapReq  in  1  trap vector load (PC+MAGIC with TRAP_MIX)
pfReq  in  1  page fail: save VMA into HELD, start retry
diagWr  in  1  front-end DATAO APR write of ADR_BRK
cycType  in  3  current memory cycle {fetch,read,write}, one-hot or zero
matchIn  in  1  VMA[13:35] equals ADR_BRK[13:35]
brkEn  in  1  address break enabled
brkMaskWr  in  1  load brkMask from brkMaskIn
brkMaskIn  in  3  new cycle-type mask
brkAck  in  1  break trap taken; clears pending
vmaSel  out  2  UCR4 control: 0=hold, 1=increment, 3=load
vmaAdSel  out  1  1=load from EDP.AD, 0=from VMA adder
condVmaMagic  out  1  adder in PC+MAGIC mode
selHeld  out  1  HELD_OR_PC mux selects HELD
loadVmaHeld  out  1  load HELD from VMA this cycle
loadAdrBrk  out  1  load ADR_BRK from EDP.AD
grant  out  4  one-hot {trap,pf,uc,diag} granted this cycle
busy  out  1  state != IDLE
brkPending  out  1  sticky address-break trap request

Behaviour:
- Reset (CROBAR high, async): state IDLE; vmaSel 0; all strobes, grant, busy, brkPending 0; brkMask=BRK_MASK_DEF; retry counter 0.
- All outputs registered; grant and selects assert the cycle after the request is sampled (latency 1). Requests are levels; a requester holds until its grant bit is seen.
- Fixed priority in IDLE: trapReq > pfReq > ucReq > diagWr. Exactly one grant bit or none per cycle. Losers get no grant and must keep requesting.
- States: IDLE, SAVE, RETRY, RESTORE.
  - IDLE + trap: vmaSel=3, vmaAdSel=0, condVmaMagic=1; stay IDLE.
  - IDLE + uc: ucSrc 0 -> vmaSel=3, vmaAdSel=1; 1 -> vmaSel=3, condVmaMagic=1; 2 -> vmaSel=3, selHeld=1; 3 -> vmaSel=1. Stay IDLE.
  - IDLE + diag: loadAdrBrk=1 for one cycle; VMA held.
  - IDLE + pf -> SAVE: loadVmaHeld=1, vmaSel=0, one cycle -> RETRY.
  - RETRY: counter loads RETRY_CYC-1 on entry, decrements each cycle, vmaSel=0; at 0 -> RESTORE. trapReq in RETRY aborts to IDLE with trap grant the next cycle. All other requests wait.
  - RESTORE: vmaSel=3, selHeld=1 for one cycle -> IDLE.
- busy=1 in SAVE/RETRY/RESTORE. ucReq and diagWr are never granted while busy.
- Address break: brkHit = brkEn & matchIn & |(cycType & brkMask), sampled every cycle in every state. brkHit sets brkPending on the next edge. brkAck clears it. If brkAck and brkHit occur in the same cycle, set wins and brkPending stays 1.
- brkMaskWr loads the mask on any cycle regardless of state. The new mask first qualifies brkHit on the following cycle.
- cycType=0: no break, whatever matchIn is.
- CROBAR mid-SAVE/RETRY aborts: no RESTORE is issued and HELD keeps whatever value it was last loaded with.

Decomposition:
- Shared package (ebox.svh): vma_src_t enum (AD, PCMAGIC, HELD, INC), vma_sel_t encoding (HOLD=0, INC=1, LOAD=3), sched_state_t enum, grant bit index constants.
- One sub-module, vma_brk_qual: mask register, brkHit compare, sticky brkPending. The FSM and arbiter stay in vma_sched.

Test Plan:
- Reset then ucReq, ucSrc=0 -> next cycle vmaSel=3, vmaAdSel=1, grant=4'b0010. ucSrc=3 -> vmaSel=1.
- trapReq, pfReq, ucReq, diagWr all high same cycle -> grant=4'b1000 with condVmaMagic=1. Drop trap -> pf granted, then uc only after RESTORE.
- pfReq with RETRY_CYC=3 -> SAVE 1 cycle (loadVmaHeld=1), RETRY 3 cycles (busy=1, vmaSel=0), RESTORE (vmaSel=3, selHeld=1), IDLE; 5 cycles total busy.
- trapReq during RETRY cycle 2 -> RESTORE skipped, trap grant the next cycle, busy=0 after.
- brkEn=1, matchIn=1, cycType=3'b010, mask=3'b010 -> brkPending=1 next cycle. Mask=3'b101 -> stays 0. brkAck with simultaneous hit -> stays 1.
- Assert CROBAR asynchronously mid-RETRY -> all outputs 0 immediately (before the next clk edge), state IDLE, brkMask=3'b111.
